// File: rtl/fp_mul_scheduler_if.sv
// rtl/fp_mul_scheduler_if.sv - request/response channels of the shared FP multiplier scheduler
interface fp_mul_scheduler_if #(
  parameter int NREQ = 2,
  parameter int ID_W = 1
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [ID_W-1:0]    rsp_id;
  logic [31:0]        rsp_data;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/fp_mul_scheduler.sv
// rtl/fp_mul_scheduler.sv - round-robin sharing of one iterative 24-bit multiplier for FP32 multiplies
module fp_mul_scheduler #(
  parameter int NREQ       = 2,
  parameter int MUL_CYCLES = 25,
  parameter int ID_W       = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  fp_mul_scheduler_if.slave bus,
  output logic              mul_start,
  output logic [23:0]       mul_a,
  output logic [23:0]       mul_b,
  input  logic [47:0]       mul_product,
  output logic              busy
);
  localparam int CNT_W = $clog2(MUL_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [ID_W:0]    NREQ_W   = (ID_W + 1)'(NREQ);
  localparam logic [ID_W:0]    ONE_W    = (ID_W + 1)'(1);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   ptr, ptr_nxt, gnt, off, id_r;
  logic [ID_W:0]     gnt_sum, ptr_sum;
  logic [NREQ-1:0]   rot;
  logic              gnt_any;
  logic [31:0]       op_a, op_b;
  logic              op_zero;
  logic              sign_r;
  logic [7:0]        exp_a_r, exp_b_r;
  logic [22:0]       frac_a_r, frac_b_r;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       rsp_data_r;
  logic              p47;
  logic [22:0]       frac_res;
  logic [7:0]        exp_res;
  logic              unused_prod_bits;

  // Rotate requests so bit 0 is the pointer position; lowest set bit wins.
  always_comb begin
    rot     = NREQ'({bus.req_valid, bus.req_valid} >> ptr);
    gnt_any = 1'b0;
    off     = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        gnt_any = 1'b1;
        off     = ID_W'(i);
      end
    end
    gnt_sum = {1'b0, ptr} + {1'b0, off};
    if (gnt_sum >= NREQ_W) gnt_sum = gnt_sum - NREQ_W;
    gnt     = gnt_sum[ID_W-1:0];
    ptr_sum = {1'b0, gnt} + ONE_W;
    ptr_nxt = (ptr_sum == NREQ_W) ? '0 : ptr_sum[ID_W-1:0];
  end

  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt == ID_W'(i)) begin
        op_a = bus.req_a[32*i +: 32];
        op_b = bus.req_b[32*i +: 32];
      end
    end
  end

  assign op_zero = (op_a[30:23] == 8'd0) || (op_b[30:23] == 8'd0);

  assign p47              = mul_product[47];
  assign frac_res         = p47 ? mul_product[46:24] : mul_product[45:23];
  assign exp_res          = exp_a_r + exp_b_r + {7'd0, p47} - 8'd127;
  assign unused_prod_bits = ^mul_product[22:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mul_start = 1'b0;
    mul_a     = '0;
    mul_b     = '0;
    case (state)
      IDLE:    if (gnt_any) state_nxt = op_zero ? RESP : START;
      START: begin
        mul_start = 1'b1;
        mul_a     = {1'b1, frac_a_r};
        mul_b     = {1'b1, frac_b_r};
        state_nxt = WAIT;
      end
      WAIT: begin
        mul_a = {1'b1, frac_a_r};
        mul_b = {1'b1, frac_b_r};
        if (cnt == CNT_LAST) state_nxt = RESP;
      end
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The zero-path result is loaded at grant; a normal result overwrites it at the end of WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= '0;
      id_r       <= '0;
      sign_r     <= 1'b0;
      exp_a_r    <= '0;
      exp_b_r    <= '0;
      frac_a_r   <= '0;
      frac_b_r   <= '0;
      cnt        <= '0;
      rsp_data_r <= '0;
    end else begin
      case (state)
        IDLE: if (gnt_any) begin
          id_r       <= gnt;
          ptr        <= ptr_nxt;
          sign_r     <= op_a[31] ^ op_b[31];
          exp_a_r    <= op_a[30:23];
          exp_b_r    <= op_b[30:23];
          frac_a_r   <= op_a[22:0];
          frac_b_r   <= op_b[22:0];
          rsp_data_r <= {op_a[31] ^ op_b[31], 31'd0};
        end
        START: cnt <= '0;
        WAIT: begin
          if (cnt == CNT_LAST) rsp_data_r <= {sign_r, exp_res, frac_res};
          else                 cnt        <= cnt + CNT_ONE;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = (rst_n && state == IDLE && gnt_any) ? (NREQ'(1) << gnt) : '0;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_id    = id_r;
  assign bus.rsp_data  = rsp_data_r;
  assign busy          = (state != IDLE);
endmodule

// File: tb/tb_fp_mul_scheduler.sv
// tb/tb_fp_mul_scheduler.sv - self-checking bench for fp_mul_scheduler with a latency-accurate multiplier model
module tb_fp_mul_scheduler;
  localparam int NREQ       = 2;
  localparam int MUL_CYCLES = 25;
  localparam int ID_W       = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mul_start;
  logic [23:0] mul_a, mul_b;
  logic [47:0] mul_product;
  logic        busy;

  fp_mul_scheduler_if #(.NREQ(NREQ), .ID_W(ID_W)) bus ();

  fp_mul_scheduler #(.NREQ(NREQ), .MUL_CYCLES(MUL_CYCLES), .ID_W(ID_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .mul_start   (mul_start),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_product (mul_product),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier model: product only valid exactly MUL_CYCLES cycles after the start cycle.
  int          mcnt = 0;
  int          mstarts = 0;
  logic [47:0] mprod = '0;
  always @(posedge clk) begin
    if (mul_start) begin
      mcnt    <= 1;
      mprod   <= {24'd0, mul_a} * {24'd0, mul_b};
      mstarts <= mstarts + 1;
    end else if (mcnt != 0 && mcnt < 1000) begin
      mcnt <= mcnt + 1;
    end
  end
  assign mul_product = (mcnt == MUL_CYCLES) ? mprod : 48'hA5A5_5A5A_0F0F;

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] data;
    int          lat;
  } exp_t;

  vec_t vecs [11];
  exp_t sbq [$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_grant(output int t, output logic [NREQ-1:0] rdy);
    int k = 0;
    #1;
    while (bus.req_ready == '0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    t   = cyc;
    rdy = bus.req_ready;
    if (bus.req_ready == '0) check("grant_timeout", bus.req_ready != '0, 1);
  endtask

  task automatic wait_rsp(input int t, output exp_t e);
    int k = 0;
    e = '{id: -1, data: '0, lat: 0};
    @(negedge clk);
    while (!bus.rsp_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!bus.rsp_valid || sbq.size() == 0) begin
      check("rsp_timeout", {bus.rsp_valid, sbq.size() != 0}, 2'b11);
    end else begin
      e = sbq.pop_front();
      check("latency", cyc - t, e.lat);
      check("rsp_id", bus.rsp_id, e.id);
      check("rsp_data", bus.rsp_data, e.data);
    end
  endtask

  task automatic collect(input int t);
    exp_t e;
    wait_rsp(t, e);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    @(negedge clk);
    check("idle_after_handshake", busy, 0);
  endtask

  task automatic run_one(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expd);
    int              t;
    int              starts0;
    logic [NREQ-1:0] rdy;
    logic            zero;
    zero    = (a[30:23] == 8'd0) || (b[30:23] == 8'd0);
    starts0 = mstarts;
    bus.req_a[32*id +: 32] = a;
    bus.req_b[32*id +: 32] = b;
    bus.req_valid[id]      = 1'b1;
    wait_grant(t, rdy);
    check("grant_onehot", rdy, NREQ'(1) << id);
    sbq.push_back('{id: id, data: expd, lat: zero ? 1 : 2 + MUL_CYCLES});
    @(posedge clk);
    #1 bus.req_valid[id] = 1'b0;
    collect(t);
    check("mul_start_count", mstarts - starts0, zero ? 0 : 1);
  endtask

  initial begin
    int              t;
    int              c;
    logic [NREQ-1:0] rdy;
    exp_t            e;

    vecs[0]  = '{0, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000};
    vecs[1]  = '{1, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000};
    vecs[2]  = '{0, 32'h0000_0000, 32'hC000_0000, 32'h8000_0000};
    vecs[3]  = '{1, 32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000};
    vecs[4]  = '{0, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000};
    vecs[5]  = '{1, 32'h4000_0000, 32'h8000_0000, 32'h8000_0000};
    vecs[6]  = '{0, 32'h3F80_0000, 32'h0000_0001, 32'h0000_0000};
    vecs[7]  = '{1, 32'h3F00_0000, 32'h3F00_0000, 32'h3E80_0000};
    vecs[8]  = '{0, 32'h3FC0_0000, 32'h3FA0_0000, 32'h3FF0_0000};
    vecs[9]  = '{1, 32'h7F00_0000, 32'h7F00_0000, 32'h3E80_0000};
    vecs[10] = '{0, 32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h407F_FFFE};

    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_mul_start", mul_start, 0);
    check("rst_mul_a", mul_a, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) run_one(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].exp);

    // Response back-pressure with the other requester waiting.
    bus.req_a[32 +: 32] = 32'h3FC0_0000;
    bus.req_b[32 +: 32] = 32'h3FC0_0000;
    bus.req_valid[1]    = 1'b1;
    wait_grant(t, rdy);
    check("hold_grant", rdy, 2'b10);
    sbq.push_back('{id: 1, data: 32'h4010_0000, lat: 2 + MUL_CYCLES});
    @(posedge clk);
    #1 bus.req_valid[1] = 1'b0;
    bus.req_a[0 +: 32] = 32'h4000_0000;
    bus.req_b[0 +: 32] = 32'h4040_0000;
    bus.req_valid[0]   = 1'b1;
    wait_rsp(t, e);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_rsp_valid", bus.rsp_valid, 1);
      check("hold_rsp_data", bus.rsp_data, 32'h4010_0000);
      check("hold_no_grant", bus.req_ready, 0);
    end
    c = cyc;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    @(negedge clk);
    wait_grant(t, rdy);
    check("hold_regrant", rdy, 2'b01);
    check("hold_regrant_cycle", t - c, 1);
    sbq.push_back('{id: 0, data: 32'h40C0_0000, lat: 2 + MUL_CYCLES});
    @(posedge clk);
    #1 bus.req_valid[0] = 1'b0;
    collect(t);

    // Reset in the middle of WAIT aborts the transaction.
    bus.req_valid[0] = 1'b1;
    wait_grant(t, rdy);
    check("abort_grant", rdy, 2'b01);
    @(posedge clk);
    #1 bus.req_valid[0] = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    check("abort_busy_before", busy, 1);
    bus.req_valid[1] = 1'b1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_mul_a", mul_a, 0);
    check("abort_mul_b", mul_b, 0);
    check("abort_mul_start", mul_start, 0);
    check("abort_rsp_valid", bus.rsp_valid, 0);
    check("abort_rsp_data", bus.rsp_data, 0);
    check("abort_rsp_id", bus.rsp_id, 0);
    check("abort_req_ready", bus.req_ready, 0);
    repeat (3) @(negedge clk);
    check("abort_req_ready_held", bus.req_ready, 0);
    rst_n = 1'b1;
    bus.req_valid[0] = 1'b1;
    wait_grant(t, rdy);
    check("post_reset_grant", rdy, 2'b01);
    sbq.push_back('{id: 0, data: 32'h40C0_0000, lat: 2 + MUL_CYCLES});
    @(posedge clk);
    #1 bus.req_valid = '0;
    collect(t);

    // Both requesters continuously valid: grants alternate starting at 0.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.req_a = {32'h3FC0_0000, 32'h4000_0000};
    bus.req_b = {32'h3FC0_0000, 32'h4040_0000};
    bus.req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_grant(t, rdy);
      check("alt_grant", rdy, (i % 2) ? 2'b10 : 2'b01);
      sbq.push_back('{id: i % 2, data: (i % 2) ? 32'h4010_0000 : 32'h40C0_0000,
                      lat: 2 + MUL_CYCLES});
      collect(t);
    end
    bus.req_valid = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
